picorv32_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port memory between the PicoRV32 native memory interface (master 0) and a second requester (master 1), such as a DMA/loader or bench backdoor. Both sides use the PicoRV32 valid/ready protocol. Masters are arbitrated round-robin; each grant holds until the memory returns ready. Sits between the core and the memory model/SRAM in the SoC and the simulation top.

---
 rtl/picorv32_arb_pkg.sv | 35 +++
 rtl/picorv32_arb_rr2.sv | 32 +++
 rtl/picorv32_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_arb_pkg.sv
// rtl/picorv32_arb_pkg.sv - shared types and constants for the PicoRV32 memory arbiter
package picorv32_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;
    localparam logic [ARB_DATA_W-1:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                  instr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] wstrb;
    } mem_req_t;

    function automatic mem_req_t arb_pack_req(
        input logic                  instr,
        input logic [ARB_ADDR_W-1:0] addr,
        input logic [ARB_DATA_W-1:0] wdata,
        input logic [ARB_STRB_W-1:0] wstrb
    );
        mem_req_t r;
        r.instr = instr;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

endpackage

// File: rtl/picorv32_arb_rr2.sv
// rtl/picorv32_arb_rr2.sv - two-way round-robin pick; a tie goes to the master that was not last
module picorv32_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       gnt_id
);

    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                grant  = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                grant  = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                grant  = last ? 2'b01 : 2'b10;
                gnt_id = ~last;
            end
            default: begin
                grant  = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - round-robin arbiter sharing one memory between two PicoRV32-style masters
// Optional BUSY watchdog abort is enabled by defining PICORV32_ARB_TIMEOUT_EN.
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int                ADDR_W         = ARB_ADDR_W,
    parameter int                DATA_W         = ARB_DATA_W,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA      = ARB_ERR_RDATA
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_valid,
    input  logic                m0_instr,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic                m1_instr,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_valid,
    output logic                s_instr,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                grant_id,
    output logic                busy,
    output logic                timeout_err
);

    arb_state_e  state_q, state_d;
    logic        s_valid_q, s_valid_d;
    mem_req_t    req_q, req_d;
    logic        grant_id_q, grant_id_d;
    logic [1:0]  mask_q, mask_d;

    logic [1:0]  elig;
    logic [1:0]  rr_grant;
    logic        rr_id;
    logic        abort;
    logic        done;
    logic        complete;
    logic [DATA_W-1:0] resp_data;

    // A master just served is masked for one IDLE cycle so a late-dropping valid is not regranted.
    assign elig = {m1_valid & ~mask_q[1], m0_valid & ~mask_q[0]};

    picorv32_arb_rr2 u_rr2 (
        .req    (elig),
        .last   (grant_id_q),
        .grant  (rr_grant),
        .gnt_id (rr_id)
    );

`ifdef PICORV32_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 9) ? $clog2(TIMEOUT_CYCLES) : 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // s_ready wins over the watchdog on the same cycle.
    assign abort = (state_q == ARB_BUSY) && !s_ready && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == ARB_IDLE) begin
            cnt_d = '0;
        end else if (!s_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (abort) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done = s_ready | abort;

    always_comb begin
        state_d    = state_q;
        s_valid_d  = s_valid_q;
        req_d      = req_q;
        grant_id_d = grant_id_q;
        mask_d     = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                if (|rr_grant) begin
                    req_d      = rr_id ? arb_pack_req(m1_instr, m1_addr, m1_wdata, m1_wstrb)
                                       : arb_pack_req(m0_instr, m0_addr, m0_wdata, m0_wstrb);
                    s_valid_d  = 1'b1;
                    grant_id_d = rr_id;
                    state_d    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    s_valid_d          = 1'b0;
                    state_d            = ARB_IDLE;
                    mask_d[grant_id_q] = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ARB_IDLE;
            s_valid_q  <= 1'b0;
            req_q      <= '0;
            grant_id_q <= 1'b1;
            mask_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            s_valid_q  <= s_valid_d;
            req_q      <= req_d;
            grant_id_q <= grant_id_d;
            mask_q     <= mask_d;
        end
    end

    assign busy      = (state_q == ARB_BUSY);
    assign complete  = busy && done;
    assign resp_data = abort ? ERR_RDATA : s_rdata;

    assign m0_ready = complete && !grant_id_q;
    assign m1_ready = complete &&  grant_id_q;
    assign m0_rdata = (busy && !grant_id_q) ? resp_data : '0;
    assign m1_rdata = (busy &&  grant_id_q) ? resp_data : '0;

    assign s_valid  = s_valid_q;
    assign s_instr  = req_q.instr;
    assign s_addr   = req_q.addr;
    assign s_wdata  = req_q.wdata;
    assign s_wstrb  = req_q.wstrb;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - scoreboard bench for picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 0;
    logic [31:0] s_rdata = 0;
    logic        grant_id, busy, timeout_err;

    typedef struct {
        int          id;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rsp0[$];
    logic [31:0] exp_rsp1[$];

    int vectors = 0;
    int miscompares = 0;
    int mem_wait = 2;
    bit mem_hold = 0;
    bit in_txn = 0;
    int wcnt = 0;
    req_t cur;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        case (addr)
            32'h10:  return 32'h1234_5678;
            32'h20:  return 32'h0BAD_F00D;
            default: return {16'h5EED, addr[15:0]};
        endcase
    endfunction

    task automatic expect_req(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr,
                              input bit has_rsp, input logic [31:0] rdata);
        req_t r;
        r.id = id; r.instr = instr; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
        exp_req.push_back(r);
        if (has_rsp) begin
            if (id == 0) exp_rsp0.push_back(rdata);
            else         exp_rsp1.push_back(rdata);
        end
    endtask

    task automatic drive(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input int hold_extra);
        bit got = 0;
        if (id == 0) begin
            m0_valid = 1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_instr = instr;
        end else begin
            m1_valid = 1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_instr = instr;
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ((id == 0) ? m0_ready : m1_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check($sformatf("m%0d_ready_wait", id), 0, 1);
        @(posedge clk);
        repeat (hold_extra) @(posedge clk);
        #1;
        if (id == 0) begin
            m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0; m0_instr = 0;
        end else begin
            m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; m1_instr = 0;
        end
    endtask

    // Memory model: checks each granted request against the expected order and stability.
    always begin
        @(posedge clk);
        #1;
        s_ready = 1'b0;
        s_rdata = '0;
        if (s_valid) begin
            if (!in_txn) begin
                in_txn = 1;
                wcnt = 0;
                if (exp_req.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                    cur = '{id: 0, instr: 0, addr: 0, wdata: 0, wstrb: 0};
                end else begin
                    cur = exp_req.pop_front();
                    check("grant_id", grant_id, cur.id[0]);
                end
            end
            check("s_req", {s_instr, s_addr, s_wdata, s_wstrb},
                  {cur.instr, cur.addr, cur.wdata, cur.wstrb});
            if (!mem_hold && wcnt >= mem_wait) begin
                s_ready = 1'b1;
                s_rdata = mem_data(s_addr);
                in_txn = 0;
            end else begin
                wcnt++;
            end
        end else begin
            in_txn = 0;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (m0_ready || m1_ready) check("exclusive_ready", m0_ready & m1_ready, 0);
        if (m0_ready) begin
            if (exp_rsp0.size() == 0) check("m0_unexpected_ready", 1, 0);
            else check("m0_rdata", m0_rdata, exp_rsp0.pop_front());
        end
        if (m1_ready) begin
            if (exp_rsp1.size() == 0) check("m1_unexpected_ready", 1, 0);
            else check("m1_rdata", m1_rdata, exp_rsp1.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 resetn = 0;
        repeat (2) @(negedge clk);
        check("rst_s_valid", s_valid, 0);
        check("rst_s_fields", {s_instr, s_addr, s_wdata, s_wstrb}, 0);
        check("rst_grant_id", grant_id, 1);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_ready", {m0_ready, m1_ready}, 0);
        resetn = 1;

        // Test 1: m0 fetch at 0x10, two wait cycles
        mem_wait = 2;
        @(posedge clk); #1;
        expect_req(0, 32'h10, 0, 4'h0, 1, 1, 32'h1234_5678);
        fork
            drive(0, 32'h10, 0, 4'h0, 1, 0);
            begin
                @(negedge clk); check("t1_s_valid_pre", s_valid, 0);
                @(negedge clk); check("t1_s_valid_post", s_valid, 1);
                check("t1_busy", busy, 1);
            end
        join
        check("t1_grant_id", grant_id, 0);

        // Test 2: simultaneous requests; last owner m0 so each tie goes to m1
        mem_wait = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            expect_req(1, 32'h200 + 8 * k, 0, 4'h0, 1, 1, 32'h5EED_0200 + 8 * k);
            expect_req(0, 32'h100 + 8 * k, 0, 4'h0, 0, 1, 32'h5EED_0100 + 8 * k);
            fork
                drive(0, 32'h100 + 8 * k, 0, 4'h0, 0, 0);
                drive(1, 32'h200 + 8 * k, 0, 4'h0, 1, 0);
            join
        end
        @(posedge clk); #1;
        expect_req(1, 32'h210, 0, 4'h0, 0, 1, 32'h5EED_0210);
        drive(1, 32'h210, 0, 4'h0, 0, 0);
        @(posedge clk); #1;
        expect_req(0, 32'h114, 0, 4'h0, 0, 1, 32'h5EED_0114);
        expect_req(1, 32'h214, 0, 4'h0, 0, 1, 32'h5EED_0214);
        fork
            drive(0, 32'h114, 0, 4'h0, 0, 0);
            drive(1, 32'h214, 0, 4'h0, 0, 0);
        join

        // Test 3: m1 write arrives while m0 is mid-transfer
        mem_wait = 3;
        @(posedge clk); #1;
        expect_req(0, 32'h30, 0, 4'h0, 0, 1, 32'h5EED_0030);
        expect_req(1, 32'h20, 32'hA5A5_A5A5, 4'b0011, 0, 1, 32'h0BAD_F00D);
        fork
            drive(0, 32'h30, 0, 4'h0, 0, 0);
            begin
                repeat (2) @(posedge clk); #1;
                drive(1, 32'h20, 32'hA5A5_A5A5, 4'b0011, 0, 0);
            end
        join

        // Test 4a: m0 holds valid one cycle past ready, nobody else pending
        mem_wait = 1;
        @(posedge clk); #1;
        expect_req(0, 32'h40, 32'h1111_2222, 4'hF, 0, 1, 32'h5EED_0040);
        drive(0, 32'h40, 32'h1111_2222, 4'hF, 0, 1);
        @(negedge clk);
        check("t4_no_regrant_busy", busy, 0);
        check("t4_no_regrant_s_valid", s_valid, 0);

        // Test 4b: same with m1 pending
        @(posedge clk); #1;
        expect_req(0, 32'h44, 0, 4'h0, 0, 1, 32'h5EED_0044);
        expect_req(1, 32'h48, 0, 4'h0, 0, 1, 32'h5EED_0048);
        fork
            drive(0, 32'h44, 0, 4'h0, 0, 1);
            begin
                repeat (2) @(posedge clk); #1;
                drive(1, 32'h48, 0, 4'h0, 0, 0);
            end
        join

        // Test 5: reset while BUSY
        mem_hold = 1;
        @(posedge clk); #1;
        expect_req(0, 32'h50, 0, 4'h0, 0, 0, 0);
        m0_valid = 1; m0_addr = 32'h50;
        repeat (3) @(negedge clk);
        check("t5_busy_before", busy, 1);
        #1 resetn = 0;
        #1;
        check("t5_s_valid_async", s_valid, 0);
        check("t5_busy_async", busy, 0);
        check("t5_no_ready", {m0_ready, m1_ready}, 0);
        m0_valid = 0; m0_addr = 0;
        mem_hold = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        check("t5_grant_id_reset", grant_id, 1);
        @(posedge clk); #1;
        expect_req(0, 32'h54, 0, 4'h0, 0, 1, 32'h5EED_0054);
        drive(0, 32'h54, 0, 4'h0, 0, 0);

`ifdef PICORV32_ARB_TIMEOUT_EN
        // Test 6: watchdog abort after 8 BUSY cycles
        mem_hold = 1;
        @(posedge clk); #1;
        expect_req(0, 32'h60, 0, 4'h0, 0, 1, 32'hDEAD_BEEF);
        fork
            drive(0, 32'h60, 0, 4'h0, 0, 0);
            begin
                n = 0;
                for (int w = 0; w < 20 && !s_valid; w++) @(negedge clk);
                n = 1;
                while (!m0_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("t6_abort_cycle", n, 8);
            end
        join
        mem_hold = 0;
        @(negedge clk);
        check("t6_timeout_err", timeout_err, 1);
        check("t6_busy_after", busy, 0);
        @(posedge clk); #1;
        expect_req(0, 32'h64, 0, 4'h0, 0, 1, 32'h5EED_0064);
        drive(0, 32'h64, 0, 4'h0, 0, 0);
        @(negedge clk);
        check("t6_timeout_err_sticky", timeout_err, 1);
`else
        @(negedge clk);
        check("timeout_err_tied", timeout_err, 0);
`endif

        repeat (3) @(negedge clk);
        check("exp_req_drained", exp_req.size(), 0);
        check("exp_rsp0_drained", exp_rsp0.size(), 0);
        check("exp_rsp1_drained", exp_rsp1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
